sipo_stream_deser: RTL and testbench



---
 rtl/sipo_pkg.sv | 18 +
 rtl/sipo_out_reg.sv | 46 ++++
 rtl/sipo_stream_deser.sv | 122 ++++++++++++
 tb/tb_sipo_stream_deser.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sipo_pkg.sv
// Shared constants and sizing helpers for the stream deserializer.
// Beat count and beat counter width are derived here from WIDTH and LANES.
package sipo_pkg;

  localparam int SHIFT_LSB_FIRST = 0;
  localparam int SHIFT_MSB_FIRST = 1;

  // Number of beats that make up one output word.
  function automatic int beats(input int width, input int lanes);
    return width / lanes;
  endfunction

  // Counter width for n beats; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sipo_out_reg.sv
// One-entry output holding register with valid/ready, load and pop.
// stall is high while a word is held and the consumer is not taking it.
module sipo_out_reg #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [DW-1:0] load_data,
  input  logic          ready,
  output logic          valid,
  output logic [DW-1:0] data,
  output logic          stall
);

  logic          valid_q, valid_d;
  logic [DW-1:0] data_q, data_d;

  // A load wins over a pop so back-to-back words keep valid high.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = load_data;
    end else if (valid_q && ready) begin
      valid_d = 1'b0;
    end
  end

  // Holding register state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid = valid_q;
  assign data  = data_q;
  assign stall = valid_q && !ready;

endmodule

// File: rtl/sipo_stream_deser.sv
// Serial-to-parallel deserializer: LANES bits per beat into WIDTH-bit words.
// Define SIPO_PARITY_EN to add the registered out_parity output.
module sipo_stream_deser
  import sipo_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int LANES     = 1,
  parameter int SHIFT_DIR = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [LANES-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  input  logic             flush,
  output logic             busy
`ifdef SIPO_PARITY_EN
  ,
  output logic             out_parity
`endif
);

  localparam int BEATS = beats(WIDTH, LANES);
  localparam int CW    = cnt_w(BEATS);
  localparam logic [CW-1:0] LAST = CW'(BEATS - 1);
  localparam bit MSB_FIRST = (SHIFT_DIR == SHIFT_MSB_FIRST);
`ifdef SIPO_PARITY_EN
  localparam int DW = WIDTH + 1;
`else
  localparam int DW = WIDTH;
`endif

  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] word;
  logic [DW-1:0]    load_data;
  logic [DW-1:0]    held;
  logic             stall;
  logic             last_beat;
  logic             accept;
  logic             load;

  assign last_beat = (cnt_q == LAST);
  assign in_ready  = !last_beat || !stall;
  assign accept    = in_valid && in_ready;
  assign load      = accept && last_beat && !flush;

  // Accumulator with the incoming beat merged at its slot.
  always_comb begin
    word = acc_q;
    for (int k = 0; k < BEATS; k++) begin
      if (cnt_q == CW'(k)) begin
        if (MSB_FIRST)
          word[WIDTH-(k+1)*LANES +: LANES] = in_data;
        else
          word[k*LANES +: LANES] = in_data;
      end
    end
  end

  // Flush beats any beat; a completing beat empties the accumulator.
  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (flush) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (accept) begin
      if (last_beat) begin
        acc_d = '0;
        cnt_d = '0;
      end else begin
        acc_d = word;
        cnt_d = cnt_q + CW'(1);
      end
    end
    busy_d = (cnt_d != '0);
  end

  // Accumulator, beat counter and busy flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

`ifdef SIPO_PARITY_EN
  assign load_data = {^word, word};
`else
  assign load_data = word;
`endif

  sipo_out_reg #(
    .DW(DW)
  ) u_out (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .load_data (load_data),
    .ready     (out_ready),
    .valid     (out_valid),
    .data      (held),
    .stall     (stall)
  );

  assign out_data = held[WIDTH-1:0];
  assign busy     = busy_q;
`ifdef SIPO_PARITY_EN
  assign out_parity = held[WIDTH];
`endif

endmodule

// File: tb/tb_sipo_stream_deser.sv
// Bench for sipo_stream_deser: 8/2 LSB-first, 8/2 MSB-first, 8/1 LSB-first.
// Word-level reference model built from queued beats and shift arithmetic.
module tb_sipo_stream_deser;

  logic       clk = 1'b0;
  logic       reset;
  logic       iv, ordy, fl;
  logic [1:0] d;
  logic       rdy0, ov0, busy0, rdy1, ov1, busy1;
  logic [7:0] od0, od1;
  logic       iv2, d2, ordy2, fl2;
  logic       rdy2, ov2, busy2;
  logic [7:0] od2;
`ifdef SIPO_PARITY_EN
  logic       par0, par1, par2;
`endif

  int n_vec = 0;
  int n_err = 0;

  int         bq[$];
  bit         hv;
  logic [7:0] hw0, hw1;

  always #5 clk = ~clk;

  sipo_stream_deser #(.WIDTH(8), .LANES(2), .SHIFT_DIR(0)) u0 (
    .clk(clk), .reset(reset), .in_valid(iv), .in_data(d),
    .in_ready(rdy0), .out_valid(ov0), .out_data(od0),
    .out_ready(ordy), .flush(fl), .busy(busy0)
`ifdef SIPO_PARITY_EN
    , .out_parity(par0)
`endif
  );

  sipo_stream_deser #(.WIDTH(8), .LANES(2), .SHIFT_DIR(1)) u1 (
    .clk(clk), .reset(reset), .in_valid(iv), .in_data(d),
    .in_ready(rdy1), .out_valid(ov1), .out_data(od1),
    .out_ready(ordy), .flush(fl), .busy(busy1)
`ifdef SIPO_PARITY_EN
    , .out_parity(par1)
`endif
  );

  sipo_stream_deser #(.WIDTH(8), .LANES(1), .SHIFT_DIR(0)) u2 (
    .clk(clk), .reset(reset), .in_valid(iv2), .in_data(d2),
    .in_ready(rdy2), .out_valid(ov2), .out_data(od2),
    .out_ready(ordy2), .flush(fl2), .busy(busy2)
`ifdef SIPO_PARITY_EN
    , .out_parity(par2)
`endif
  );

  function automatic bit exp_ready();
    return (bq.size() != 3) || !hv || ordy;
  endfunction

  task automatic model_clear();
    bq.delete();
    hv  = 1'b0;
    hw0 = '0;
    hw1 = '0;
  endtask

  task automatic set_in(input logic v, input logic [1:0] dd,
                        input logic r, input logic f);
    iv = v; d = dd; ordy = r; fl = f;
  endtask

  // Advance one clock; the model follows the u0/u1 inputs.
  task automatic tick();
    bit rm, pop, ld;
    rm  = exp_ready();
    pop = hv && ordy;
    ld  = 1'b0;
    @(posedge clk);
    if (fl) begin
      bq.delete();
    end else if (iv && rm) begin
      bq.push_back(int'(d));
      if (bq.size() == 4) begin
        hw0 = '0;
        hw1 = '0;
        for (int k = 0; k < 4; k++) begin
          hw0 = hw0 | 8'(bq[k] << (2 * k));
          hw1 = hw1 | 8'(bq[k] << (6 - 2 * k));
        end
        ld = 1'b1;
        bq.delete();
      end
    end
    if (ld) hv = 1'b1;
    else if (pop) hv = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_in(1'b0, 2'b00, 1'b0, 1'b0);
    iv2 = 1'b0; d2 = 1'b0; ordy2 = 1'b0; fl2 = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    if ({ov0, od0, busy0} !== 10'd0) begin
      n_err++;
      $display("FAIL reset_u0 got v=%b d=%h b=%b exp 0", ov0, od0, busy0);
    end
    n_vec++;
    if ({ov1, od1, busy1, ov2, od2, busy2} !== 20'd0) begin
      n_err++;
      $display("FAIL reset_u1u2 got %h/%h exp 0", od1, od2);
    end
    n_vec++;
    if ({rdy0, rdy2} !== 2'b11) begin
      n_err++;
      $display("FAIL reset_ready got %b%b exp 11", rdy0, rdy2);
    end
    n_vec++;
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    logic [1:0] b[4];
    b[0] = 2'b01; b[1] = 2'b10; b[2] = 2'b11; b[3] = 2'b00;
    for (int k = 0; k < 4; k++) begin
      set_in(1'b1, b[k], 1'b1, 1'b0);
      tick();
      if (busy0 !== (k != 3) || ov0 !== (k == 3)) begin
        n_err++;
        $display("FAIL basic_beat%0d got busy=%b v=%b", k, busy0, ov0);
      end
      n_vec++;
    end
    if (od0 !== 8'h39 || od1 !== 8'h6C) begin
      n_err++;
      $display("FAIL basic_word got %h/%h exp 39/6c", od0, od1);
    end
    n_vec++;
`ifdef SIPO_PARITY_EN
    if (par0 !== 1'b0 || par1 !== 1'b0) begin
      n_err++;
      $display("FAIL parity_39 got %b%b exp 00", par0, par1);
    end
    n_vec++;
`endif
    set_in(1'b0, 2'b00, 1'b1, 1'b0);
    tick();
    if (ov0 !== 1'b0 || ov1 !== 1'b0) begin
      n_err++;
      $display("FAIL basic_pulse got %b%b exp 00", ov0, ov1);
    end
    n_vec++;
`ifdef SIPO_PARITY_EN
    b[0] = 2'b00; b[1] = 2'b10; b[2] = 2'b11; b[3] = 2'b00;
    for (int k = 0; k < 4; k++) begin
      set_in(1'b1, b[k], 1'b1, 1'b0);
      tick();
    end
    if (od0 !== 8'h38 || par0 !== 1'b1 || ov0 !== 1'b1) begin
      n_err++;
      $display("FAIL parity_38 got %h p=%b v=%b", od0, par0, ov0);
    end
    n_vec++;
    set_in(1'b0, 2'b00, 1'b1, 1'b0);
    tick();
`endif
  endtask

  task automatic test_flush();
    set_in(1'b1, 2'b01, 1'b1, 1'b0);
    tick();
    set_in(1'b1, 2'b10, 1'b1, 1'b0);
    tick();
    set_in(1'b1, 2'b11, 1'b1, 1'b1);
    tick();
    if (busy0 !== 1'b0 || ov0 !== 1'b0) begin
      n_err++;
      $display("FAIL flush_mid got busy=%b v=%b exp 0 0", busy0, ov0);
    end
    n_vec++;
    for (int k = 0; k < 3; k++) begin
      set_in(1'b1, 2'b10, 1'b1, 1'b0);
      tick();
    end
    set_in(1'b1, 2'b01, 1'b1, 1'b1);
    tick();
    if (busy0 !== 1'b0 || ov0 !== 1'b0) begin
      n_err++;
      $display("FAIL flush_final got busy=%b v=%b exp 0 0", busy0, ov0);
    end
    n_vec++;
    for (int k = 0; k < 4; k++) begin
      set_in(1'b1, 2'b11, 1'b1, 1'b0);
      tick();
      if (ov0 !== (k == 3)) begin
        n_err++;
        $display("FAIL flush_next%0d got v=%b", k, ov0);
      end
      n_vec++;
    end
    if (od0 !== 8'hFF || od1 !== 8'hFF) begin
      n_err++;
      $display("FAIL flush_word got %h/%h exp ff/ff", od0, od1);
    end
    n_vec++;
    set_in(1'b0, 2'b00, 1'b1, 1'b0);
    tick();
  endtask

  task automatic test_backpressure();
    logic [7:0] wa, wb;
    wa = 8'hA5;
    wb = 8'h3C;
    set_in(1'b0, 2'b00, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      iv2 = 1'b1; d2 = wa[i]; ordy2 = 1'b0;
      tick();
    end
    if (ov2 !== 1'b1 || od2 !== 8'hA5) begin
      n_err++;
      $display("FAIL bp_first got v=%b d=%h exp 1 a5", ov2, od2);
    end
    n_vec++;
    for (int i = 0; i < 7; i++) begin
      d2 = wb[i];
      #1;
      if (rdy2 !== 1'b1) begin
        n_err++;
        $display("FAIL bp_accept%0d got rdy=%b exp 1", i, rdy2);
      end
      n_vec++;
      tick();
    end
    if (busy2 !== 1'b1) begin
      n_err++;
      $display("FAIL bp_busy got %b exp 1", busy2);
    end
    n_vec++;
    d2 = wb[7];
    #1;
    if (rdy2 !== 1'b0) begin
      n_err++;
      $display("FAIL bp_stall got rdy=%b exp 0", rdy2);
    end
    n_vec++;
    tick();
    if (ov2 !== 1'b1 || od2 !== 8'hA5) begin
      n_err++;
      $display("FAIL bp_hold got v=%b d=%h exp 1 a5", ov2, od2);
    end
    n_vec++;
    ordy2 = 1'b1;
    #1;
    if (rdy2 !== 1'b1) begin
      n_err++;
      $display("FAIL bp_release got rdy=%b exp 1", rdy2);
    end
    n_vec++;
    tick();
    if (ov2 !== 1'b1 || od2 !== 8'h3C || busy2 !== 1'b0) begin
      n_err++;
      $display("FAIL bp_b2b got v=%b d=%h b=%b exp 1 3c 0", ov2, od2, busy2);
    end
    n_vec++;
`ifdef SIPO_PARITY_EN
    if (par2 !== 1'b0) begin
      n_err++;
      $display("FAIL bp_parity got %b exp 0", par2);
    end
    n_vec++;
`endif
    iv2 = 1'b0;
    tick();
    if (ov2 !== 1'b0) begin
      n_err++;
      $display("FAIL bp_pop got v=%b exp 0", ov2);
    end
    n_vec++;
    ordy2 = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [1:0] b[4];
    b[0] = 2'b01; b[1] = 2'b10; b[2] = 2'b11; b[3] = 2'b00;
    for (int k = 0; k < 4; k++) begin
      set_in(1'b1, b[k], 1'b0, 1'b0);
      tick();
    end
    for (int k = 0; k < 3; k++) begin
      set_in(1'b1, 2'($urandom_range(0, 3)), 1'b0, 1'b0);
      tick();
    end
    if (ov0 !== 1'b1 || busy0 !== 1'b1 || od0 !== 8'h39) begin
      n_err++;
      $display("FAIL rmid_pre got v=%b b=%b d=%h", ov0, busy0, od0);
    end
    n_vec++;
    set_in(1'b0, 2'b00, 1'b0, 1'b0);
    #1;
    reset = 1'b1;
    #1;
    if (ov0 !== 1'b0 || od0 !== 8'h00 || busy0 !== 1'b0 || ov1 !== 1'b0) begin
      n_err++;
      $display("FAIL rmid_async got v=%b d=%h b=%b", ov0, od0, busy0);
    end
    n_vec++;
    model_clear();
    @(posedge clk);
    #1;
    reset = 1'b0;
    b[0] = 2'b11; b[1] = 2'b00; b[2] = 2'b01; b[3] = 2'b10;
    for (int k = 0; k < 4; k++) begin
      set_in(1'b1, b[k], 1'b1, 1'b0);
      tick();
    end
    if (ov0 !== 1'b1 || od0 !== 8'h93 || od1 !== 8'hC6) begin
      n_err++;
      $display("FAIL rmid_after got %h/%h exp 93/c6", od0, od1);
    end
    n_vec++;
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      set_in(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
             1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 11) == 0));
      #1;
      if (rdy0 !== exp_ready() || rdy1 !== exp_ready()) begin
        n_err++;
        $display("FAIL rnd_ready c=%0d got %b%b exp %b", c, rdy0, rdy1,
                 exp_ready());
      end
      n_vec++;
      tick();
      if (ov0 !== hv || od0 !== hw0 || busy0 !== (bq.size() != 0)) begin
        n_err++;
        $display("FAIL rnd_u0 c=%0d got v=%b d=%h b=%b exp %b %h %b", c,
                 ov0, od0, busy0, hv, hw0, bq.size() != 0);
      end
      n_vec++;
      if (ov1 !== hv || od1 !== hw1 || busy1 !== (bq.size() != 0)) begin
        n_err++;
        $display("FAIL rnd_u1 c=%0d got v=%b d=%h exp %b %h", c,
                 ov1, od1, hv, hw1);
      end
      n_vec++;
`ifdef SIPO_PARITY_EN
      if (par0 !== ^hw0 || par1 !== ^hw1) begin
        n_err++;
        $display("FAIL rnd_parity c=%0d got %b%b", c, par0, par1);
      end
      n_vec++;
`endif
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_flush();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
